// File: rtl/mem_port_arbiter.sv
// Two-client round-robin arbiter in front of a single-port synchronous RAM.
// Grants one request per cycle, drives the RAM port and steers read data
// (returned one cycle after grant) back to the client that issued the read.
module mem_port_arbiter #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  a_valid,
   output logic                  a_ready,
   input  logic                  a_write_en,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   input  logic [DATA_WIDTH-1:0] a_wdata,
   output logic                  a_rsp_valid,
   output logic [DATA_WIDTH-1:0] a_rsp_data,
   input  logic                  b_valid,
   output logic                  b_ready,
   input  logic                  b_write_en,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   input  logic [DATA_WIDTH-1:0] b_wdata,
   output logic                  b_rsp_valid,
   output logic [DATA_WIDTH-1:0] b_rsp_data,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_data_in,
   output logic                  mem_write_en,
   input  logic [DATA_WIDTH-1:0] mem_data_out
);

   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

   logic prio_q, prio_d;
   logic rd_pend_q, rd_pend_d;
   logic rd_port_q, rd_port_d;
   logic gnt_a, gnt_b;

   // Grant selection; reset holds both grants low so the RAM sees no write.
   always_comb begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
      if (rst_n) begin
         if (a_valid && b_valid) begin
            gnt_a = (prio_q == PORT_A);
            gnt_b = (prio_q == PORT_B);
         end else begin
            gnt_a = a_valid;
            gnt_b = b_valid;
         end
      end
   end

   // Next-state: priority flips to the loser, read tracking follows the grant.
   always_comb begin
      prio_d    = prio_q;
      rd_pend_d = 1'b0;
      rd_port_d = PORT_A;
      if (gnt_a) begin
         prio_d    = PORT_B;
         rd_pend_d = !a_write_en;
      end else if (gnt_b) begin
         prio_d    = PORT_A;
         rd_pend_d = !b_write_en;
         rd_port_d = !b_write_en;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio_q    <= PORT_A;
         rd_pend_q <= 1'b0;
         rd_port_q <= PORT_A;
      end else begin
         prio_q    <= prio_d;
         rd_pend_q <= rd_pend_d;
         rd_port_q <= rd_port_d;
      end
   end

   // RAM port drive and handshake outputs; idle drives zeros.
   always_comb begin
      a_ready      = gnt_a;
      b_ready      = gnt_b;
      mem_addr     = '0;
      mem_data_in  = '0;
      mem_write_en = 1'b0;
      if (gnt_a) begin
         mem_addr     = a_addr;
         mem_data_in  = a_wdata;
         mem_write_en = a_write_en;
      end else if (gnt_b) begin
         mem_addr     = b_addr;
         mem_data_in  = b_wdata;
         mem_write_en = b_write_en;
      end
   end

   // Read response steering; data is zeroed when not valid for that client.
   always_comb begin
      a_rsp_valid = rd_pend_q && (rd_port_q == PORT_A);
      b_rsp_valid = rd_pend_q && (rd_port_q == PORT_B);
      a_rsp_data  = a_rsp_valid ? mem_data_out : '0;
      b_rsp_data  = b_rsp_valid ? mem_data_out : '0;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter with a behavioural single-port RAM
// (registered read address). Expected read responses go into a queue
// and are checked by an independent response monitor.
module tb_mem_port_arbiter;

   logic       clk;
   logic       rst_n;
   logic       a_valid, a_ready, a_write_en, a_rsp_valid;
   logic [7:0] a_addr, a_wdata, a_rsp_data;
   logic       b_valid, b_ready, b_write_en, b_rsp_valid;
   logic [7:0] b_addr, b_wdata, b_rsp_data;
   logic [7:0] mem_addr, mem_data_in, mem_data_out;
   logic       mem_write_en;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   typedef struct {
      logic       port;
      logic [7:0] data;
      int         due;
   } exp_t;

   exp_t sb[$];
   exp_t e;

   mem_port_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_ready(a_ready), .a_write_en(a_write_en),
      .a_addr(a_addr), .a_wdata(a_wdata),
      .a_rsp_valid(a_rsp_valid), .a_rsp_data(a_rsp_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_write_en(b_write_en),
      .b_addr(b_addr), .b_wdata(b_wdata),
      .b_rsp_valid(b_rsp_valid), .b_rsp_data(b_rsp_data),
      .mem_addr(mem_addr), .mem_data_in(mem_data_in),
      .mem_write_en(mem_write_en), .mem_data_out(mem_data_out)
   );

   // Behavioural RAM: contents reloaded to addr ^ 0xA5 while in reset.
   logic [7:0] ram [256];
   logic [7:0] ram_addr_q;
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 256; i++) ram[i] <= 8'(i) ^ 8'hA5;
      end else if (mem_write_en) begin
         ram[mem_addr] <= mem_data_in;
      end
      ram_addr_q <= mem_addr;
   end
   assign mem_data_out = ram[ram_addr_q];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Response monitor: pops the queue whenever a response is presented.
   always @(negedge clk) begin
      if (rst_n) begin
         if (sb.size() > 0 && sb[0].due < cyc) begin
            chk("rsp_missing", 32'(sb[0].due), 32'(cyc));
            void'(sb.pop_front());
         end
         if (a_rsp_valid || b_rsp_valid) begin
            if (sb.size() == 0) begin
               chk("rsp_unexpected", {30'd0, a_rsp_valid, b_rsp_valid}, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("rsp_cycle",   32'(cyc), 32'(e.due));
               chk("rsp_a_valid", 32'(a_rsp_valid), 32'(!e.port));
               chk("rsp_b_valid", 32'(b_rsp_valid), 32'(e.port));
               chk("rsp_data",    32'(e.port ? b_rsp_data : a_rsp_data), 32'(e.data));
               chk("rsp_idle_data", 32'(e.port ? a_rsp_data : b_rsp_data), 32'd0);
            end
         end
      end
   end

   // One cycle: drive request fields, check grant and RAM drive, queue read data.
   task automatic step(input logic av, input logic aw, input logic [7:0] aa, input logic [7:0] ad,
                       input logic bv, input logic bw, input logic [7:0] ba, input logic [7:0] bd,
                       input logic ega, input logic egb, input logic [7:0] edata);
      logic [7:0] ea, ed;
      logic       ew;
      a_valid = av; a_write_en = aw; a_addr = aa; a_wdata = ad;
      b_valid = bv; b_write_en = bw; b_addr = ba; b_wdata = bd;
      ea = ega ? aa : (egb ? ba : 8'h00);
      ed = ega ? ad : (egb ? bd : 8'h00);
      ew = ega ? aw : (egb ? bw : 1'b0);
      @(negedge clk);
      chk("a_ready",      32'(a_ready), 32'(ega));
      chk("b_ready",      32'(b_ready), 32'(egb));
      chk("mem_write_en", 32'(mem_write_en), 32'(ew));
      chk("mem_addr",     32'(mem_addr), 32'(ea));
      chk("mem_data_in",  32'(mem_data_in), 32'(ed));
      if (ega && !aw) sb.push_back('{port: 1'b0, data: edata, due: cyc + 1});
      if (egb && !bw) sb.push_back('{port: 1'b1, data: edata, due: cyc + 1});
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00);
   endtask

   initial begin
      // Reset with both clients requesting writes.
      rst_n = 1'b0;
      a_valid = 1; a_write_en = 1; a_addr = 8'h10; a_wdata = 8'hEE;
      b_valid = 1; b_write_en = 1; b_addr = 8'h11; b_wdata = 8'hDD;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_a_ready",      32'(a_ready), 32'd0);
      chk("rst_b_ready",      32'(b_ready), 32'd0);
      chk("rst_mem_write_en", 32'(mem_write_en), 32'd0);
      chk("rst_mem_addr",     32'(mem_addr), 32'd0);
      chk("rst_a_rsp_valid",  32'(a_rsp_valid), 32'd0);
      chk("rst_b_rsp_valid",  32'(b_rsp_valid), 32'd0);
      a_valid = 0; b_valid = 0;
      rst_n = 1'b1;

      // Idle then single client write/read of 0x10.
      idle();
      step(1, 1, 8'h10, 8'h5A, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00);
      step(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 8'h5A);
      idle();

      // B alone sets prio back to A, then contention alternates A,B,A,B.
      step(0, 0, 8'h00, 8'h00, 1, 0, 8'h40, 8'h00, 0, 1, 8'hE5);
      step(1, 0, 8'h20, 8'h00, 1, 0, 8'h30, 8'h00, 1, 0, 8'h85);
      step(1, 0, 8'h21, 8'h00, 1, 0, 8'h30, 8'h00, 0, 1, 8'h95);
      step(1, 0, 8'h21, 8'h00, 1, 0, 8'h31, 8'h00, 1, 0, 8'h84);
      step(1, 0, 8'h22, 8'h00, 1, 0, 8'h31, 8'h00, 0, 1, 8'h94);
      idle();

      // Priority memory: B alone, both -> A, A alone -> A, both -> B, A alone.
      step(0, 0, 8'h00, 8'h00, 1, 0, 8'h50, 8'h00, 0, 1, 8'hF5);
      step(1, 0, 8'h60, 8'h00, 1, 0, 8'h70, 8'h00, 1, 0, 8'hC5);
      step(1, 0, 8'h61, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 8'hC4);
      step(1, 0, 8'h62, 8'h00, 1, 0, 8'h70, 8'h00, 0, 1, 8'hD5);
      step(1, 0, 8'h62, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 8'hC7);

      // Cross-client coherence at 0xFF and 0x00.
      step(0, 0, 8'h00, 8'h00, 1, 1, 8'hFF, 8'hC3, 0, 1, 8'h00);
      step(1, 0, 8'hFF, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 8'hC3);
      step(0, 0, 8'h00, 8'h00, 1, 1, 8'h00, 8'h11, 0, 1, 8'h00);
      step(1, 0, 8'h00, 8'h00, 1, 0, 8'hFF, 8'h00, 1, 0, 8'h11);
      step(0, 0, 8'h00, 8'h00, 1, 0, 8'hFF, 8'h00, 0, 1, 8'hC3);

      // Idle cycles leave RAM untouched.
      idle();
      idle();
      step(0, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00, 0, 1, 8'h5A);
      idle();

      // Reset while a read response is on the bus.
      step(1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 8'h85);
      chk("pre_rst_a_rsp_valid", 32'(a_rsp_valid), 32'd1);
      a_write_en = 1; a_wdata = 8'h77;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_a_rsp_valid",  32'(a_rsp_valid), 32'd0);
      chk("mid_rst_a_rsp_data",   32'(a_rsp_data), 32'd0);
      chk("mid_rst_a_ready",      32'(a_ready), 32'd0);
      chk("mid_rst_mem_write_en", 32'(mem_write_en), 32'd0);
      sb.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(1, 0, 8'h23, 8'h00, 1, 0, 8'h33, 8'h00, 1, 0, 8'h86);
      step(0, 0, 8'h00, 8'h00, 1, 0, 8'h33, 8'h00, 0, 1, 8'h96);
      idle();
      idle();

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
